// File: rtl/bias_sched_pkg.sv
// Shared widths, state encoding and data types for the bias-add sequencer.
package bias_sched_pkg;

   localparam int SUM_W    = 34;
   localparam int RES_W    = SUM_W + 1;
   localparam int N_CH_MAX = 4;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

   typedef logic [SUM_W-1:0] sum_t;
   typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/bias_add_sched_add_bias.sv
// Four-channel bias adder: zero-extends the unsigned sum and adds the selected
// channel bias; the carry-out lands in the top result bit, no saturation.
module add_Bias
   import bias_sched_pkg::*;
#(
   parameter res_t BIAS0 = 35'h0AAAAAAAA,
   parameter res_t BIAS1 = 35'h0AAAAAAAA,
   parameter res_t BIAS2 = 35'h0AAAAAAAA,
   parameter res_t BIAS3 = 35'h0AAAAAAAA
) (
   input  logic [1:0] Bias_sel,
   input  sum_t       adder_res,
   output res_t       bias_sum
);

   res_t bias_val;

   always_comb begin
      bias_val = BIAS0;
      case (Bias_sel)
         2'd0: bias_val = BIAS0;
         2'd1: bias_val = BIAS1;
         2'd2: bias_val = BIAS2;
         2'd3: bias_val = BIAS3;
         default: bias_val = BIAS0;
      endcase
   end

   assign bias_sum = res_t'(adder_res) + bias_val;

endmodule

// File: rtl/bias_add_sched.sv
// Frame sequencer around add_Bias: takes a round-robin channel stream of sums,
// biases each one and presents it through a single output register stage.
//
// state | meaning
// IDLE  | waiting for start; no sums accepted
// RUN   | accepting sums, one per cycle when the output stage can move
// DRAIN | last sum taken; waiting for its result to be handed off
module bias_add_sched
   import bias_sched_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int N_PIX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic       s_valid,
   output logic       s_ready,
   input  sum_t       s_data,
   output logic       m_valid,
   input  logic       m_ready,
   output res_t       m_data,
   output logic [1:0] m_ch,
   output logic       m_last
);

   localparam int               PIX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic [1:0]       CH_LAST  = 2'(N_CH - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

   sched_state_t     state_q, state_d;
   logic [1:0]       ch_cnt_q, ch_cnt_d;
   logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
   logic             m_valid_q, m_valid_d;
   res_t             m_data_q, m_data_d;
   logic [1:0]       m_ch_q, m_ch_d;
   logic             m_last_q, m_last_d;
   logic             done_q, done_d;

   logic accept;
   logic last_sum;
   res_t biased;

   add_Bias u_add_bias (
      .Bias_sel  (ch_cnt_q),
      .adder_res (s_data),
      .bias_sum  (biased)
   );

   // The output register may reload in the same cycle it is drained.
   assign s_ready  = (state_q == RUN) && (!m_valid_q || m_ready);
   assign accept   = s_valid && s_ready;
   assign last_sum = (ch_cnt_q == CH_LAST) && (pix_cnt_q == PIX_LAST);

   always_comb begin
      state_d   = state_q;
      ch_cnt_d  = ch_cnt_q;
      pix_cnt_d = pix_cnt_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ch_d    = m_ch_q;
      m_last_d  = m_last_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               ch_cnt_d  = '0;
               pix_cnt_d = '0;
            end
         end
         RUN: begin
            if (accept && last_sum) state_d = DRAIN;
         end
         DRAIN: begin
            if (m_valid_q && m_ready && m_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = biased;
         m_ch_d    = ch_cnt_q;
         m_last_d  = last_sum;
         if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d  = '0;
            pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
         end else begin
            ch_cnt_d  = ch_cnt_q + 2'd1;
         end
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ch_cnt_q  <= '0;
         pix_cnt_q <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ch_q    <= '0;
         m_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_cnt_q  <= ch_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ch_q    <= m_ch_d;
         m_last_q  <= m_last_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == RUN) || (state_q == DRAIN);
   assign done    = done_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_ch    = m_ch_q;
   assign m_last  = m_last_q;

endmodule

// File: tb/tb_bias_add_sched.sv
// Scoreboard bench: a 16-pixel instance under random traffic and a 1-pixel
// instance with a fixed four-sum frame.
module tb_bias_add_sched;
   import bias_sched_pkg::*;

   localparam int   NP   = 16;
   localparam int   NS   = NP * 4;
   localparam res_t BIAS = 35'h0AAAAAAAA;

   typedef struct {
      res_t       d;
      logic [1:0] ch;
      logic       last;
      logic       is_max;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start, busy, done, s_valid, s_ready, m_valid, m_ready, m_last;
   sum_t       s_data;
   res_t       m_data;
   logic [1:0] m_ch;

   logic       start1, busy1, done1, s_valid1, s_ready1, m_valid1, m_ready1, m_last1;
   sum_t       s_data1;
   res_t       m_data1;
   logic [1:0] m_ch1;

   bias_add_sched #(.N_CH(4), .N_PIX(NP)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_last(m_last)
   );

   bias_add_sched #(.N_CH(4), .N_PIX(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
      .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_ch(m_ch1), .m_last(m_last1)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endfunction

   // Reference model state
   exp_t q[$];
   exp_t q1[$];
   int   cyc = 0;
   int   acc_cnt = 0;
   bit   run_m = 0;
   bit   frame_active = 0;
   bit   done_exp = 0;
   bit   done1_exp = 0;
   bit   frame_end_seen = 0;
   int   n_out = 0, n_last = 0;
   int   first_acc_cyc = -1, first_out_cyc = -1, hs_cyc = -1;

   // Sampler: records accepted sums and frame starts at the clock edge.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         q.delete();
         run_m        = 0;
         frame_active = 0;
         acc_cnt      = 0;
      end else begin
         if (s_valid && s_ready) begin
            e.d      = res_t'(s_data) + BIAS;
            e.ch     = 2'(acc_cnt % 4);
            e.last   = (acc_cnt == NS - 1);
            e.is_max = (s_data == '1);
            q.push_back(e);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (acc_cnt == NS - 1) run_m = 0;
            acc_cnt = (acc_cnt + 1) % NS;
         end
         if (start && !frame_active) begin
            frame_active = 1;
            run_m        = 1;
            acc_cnt      = 0;
         end
      end
   end

   // Monitor for the 16-pixel instance.
   always @(negedge clk) begin
      if (rst) begin
         done_exp = 0;
      end else begin
         chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
         chk("s_ready", 64'(s_ready), 64'(run_m && (q.size() == 0 || m_ready)));
         chk("busy", 64'(busy), 64'(frame_active));
         chk("done", 64'(done), 64'(done_exp));
         done_exp = 0;
         if (m_valid && q.size() != 0) begin
            chk("m_data", 64'(m_data), 64'(q[0].d));
            chk("m_ch", 64'(m_ch), 64'(q[0].ch));
            chk("m_last", 64'(m_last), 64'(q[0].last));
            if (q[0].is_max) chk("max_sum", 64'(m_data), 64'(35'h4AAAAAAA9));
            if (m_ready) begin
               hs_cyc = cyc;
               if (first_out_cyc < 0) first_out_cyc = cyc;
               n_out++;
               if (q[0].last) begin
                  n_last++;
                  frame_active   = 0;
                  done_exp       = 1;
                  frame_end_seen = 1;
               end
               void'(q.pop_front());
            end
         end
      end
   end

   // Monitor for the 1-pixel instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         done1_exp = 0;
      end else begin
         chk("d1_done", 64'(done1), 64'(done1_exp));
         if (done1_exp) chk("d1_busy_fall", 64'(busy1), 64'd0);
         done1_exp = 0;
         if (m_valid1 && m_ready1) begin
            if (q1.size() == 0) begin
               chk("d1_extra_output", 64'd1, 64'(q1.size()));
            end else begin
               e = q1.pop_front();
               chk("d1_m_data", 64'(m_data1), 64'(e.d));
               chk("d1_m_ch", 64'(m_ch1), 64'(e.ch));
               chk("d1_m_last", 64'(m_last1), 64'(e.last));
               chk("d1_busy_hs", 64'(busy1), 64'd1);
               if (e.last) done1_exp = 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input bit rnd_v, input bit rnd_r, input bit stall,
                            input int start_at, input int rst_at);
      int          stall_left = 0;
      bit          stalled = 0;
      bit          restarted = 0;
      logic [63:0] r;
      n_out = 0; n_last = 0; frame_end_seen = 0;
      first_acc_cyc = -1; first_out_cyc = -1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (frame_end_seen) break;
         if (rst_at >= 0 && acc_cnt == rst_at) begin
            rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
            step();
            rst = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            step();
            return;
         end
         if (start_at >= 0 && !restarted && acc_cnt == start_at) begin
            start = 1'b1;
            restarted = 1;
         end else begin
            start = 1'b0;
         end
         s_valid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
         r = {$urandom, $urandom};
         s_data = (acc_cnt == 2 || $urandom_range(0, 7) == 0) ? '1 : r[SUM_W-1:0];
         m_ready = rnd_r ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         if (stall && !stalled && acc_cnt >= 1) begin
            stall_left = 5;
            stalled = 1;
         end
         if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end
         step();
      end
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      chk("frame_timeout", 64'(frame_end_seen), 64'd1);
      repeat (3) step();
      chk("n_out", 64'(n_out), 64'(NS));
      chk("n_last", 64'(n_last), 64'd1);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      start1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0; m_ready1 = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_m_valid", 64'(m_valid), 64'd0);
      chk("reset_m_data", 64'(m_data), 64'd0);
      chk("reset_m_ch", 64'(m_ch), 64'd0);
      chk("reset_m_last", 64'(m_last), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_s_ready", 64'(s_ready), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      step();

      // Single-pixel frame with sums 1..4.
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid1 = 1'b1;
         s_data1  = sum_t'(i + 1);
         e.d      = 35'h0AAAAAAAB + res_t'(i);
         e.ch     = 2'(i);
         e.last   = (i == 3);
         e.is_max = 1'b0;
         q1.push_back(e);
         step();
      end
      s_valid1 = 1'b0;
      repeat (4) step();
      chk("d1_all_out", 64'(q1.size()), 64'd0);

      // Continuous traffic: full throughput and one-cycle latency.
      run_frame(0, 0, 0, -1, -1);
      chk("latency", 64'(first_out_cyc), 64'(first_acc_cyc));
      chk("throughput", 64'(hs_cyc - first_acc_cyc), 64'(NS - 1));

      // Five-cycle stall after the first result.
      run_frame(0, 0, 1, -1, -1);

      // Stray start mid-frame.
      run_frame(1, 0, 0, 10, -1);

      // Random valid and ready.
      run_frame(1, 1, 0, -1, -1);
      run_frame(1, 1, 1, -1, -1);

      // Reset with a result pending, then a fresh frame.
      run_frame(0, 0, 0, -1, 7);
      run_frame(0, 1, 0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
